// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word requests on a pipelined instruction bus,
// buffers in-order responses in a 2-entry FIFO and presents the head to IF/ID.
// Redirects flush the FIFO and discard responses still owed to the old path.
module if_fetch #(
    parameter logic [31:0] RST_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        jmp_en_i,
    input  logic [31:0] jmp_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    localparam logic [31:0] RST_WORD = {RST_ADDR[31:2], 2'b00};

    state_t      state_r;
    state_t      state_s;
    logic [31:0] fpc_r;
    logic [31:0] fpc_s;
    logic [1:0]  out_cnt_r;
    logic [1:0]  out_cnt_s;
    logic [1:0]  disc_cnt_r;
    logic [1:0]  disc_cnt_s;

    logic [31:0] fifo_pc_r   [2];
    logic [31:0] fifo_inst_r [2];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  fifo_cnt_r;

    logic        req_s;
    logic        accept_s;
    logic        rsp_s;
    logic        push_s;
    logic        pop_s;
    logic [2:0]  occ_s;
    logic [31:0] jmp_pc_s;
    logic [31:0] resp_pc_s;

    // Bus handshake, FIFO push/pop decisions and request credit.
    always_comb begin
        // A response with nothing outstanding is a leftover from before reset.
        rsp_s    = ibus_rvalid_i && (out_cnt_r != 2'd0);
        pop_s    = (fifo_cnt_r != 2'd0) && !hold_i && !jmp_en_i;
        // Responses during a redirect or while discarding belong to the old path.
        push_s   = rsp_s && (disc_cnt_r == 2'd0) && !jmp_en_i;
        // Occupancy after this cycle's pop; keeps outstanding + buffered <= 2.
        occ_s    = {1'b0, out_cnt_r} + {1'b0, fifo_cnt_r} - {2'b00, pop_s};
        if ((state_r == RUN) && (occ_s < 3'd2)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
        accept_s = req_s && ibus_gnt_i;
        jmp_pc_s = jmp_addr_i & 32'hFFFF_FFFC;
        // Requests since the last redirect are sequential, so the oldest one
        // in flight sits out_cnt_r words behind the fetch PC.
        resp_pc_s = fpc_r - {28'd0, out_cnt_r, 2'b00};
    end

    // Next outstanding count, discard count, fetch PC and FSM state.
    always_comb begin
        out_cnt_s  = out_cnt_r;
        disc_cnt_s = disc_cnt_r;
        fpc_s      = fpc_r;
        state_s    = state_r;

        case ({accept_s, rsp_s})
            2'b10:   out_cnt_s = out_cnt_r + 2'd1;
            2'b01:   out_cnt_s = out_cnt_r - 2'd1;
            default: out_cnt_s = out_cnt_r;
        endcase

        if (jmp_en_i) begin
            disc_cnt_s = out_cnt_s;
        end else if (rsp_s && (disc_cnt_r != 2'd0)) begin
            disc_cnt_s = disc_cnt_r - 2'd1;
        end else begin
            disc_cnt_s = disc_cnt_r;
        end

        if (jmp_en_i) begin
            fpc_s = jmp_pc_s;
        end else if (accept_s) begin
            fpc_s = fpc_r + 32'd4;
        end else begin
            fpc_s = fpc_r;
        end

        case (state_r)
            BOOT: begin
                state_s = RUN;
            end
            RUN: begin
                if (jmp_en_i && (out_cnt_s != 2'd0)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (disc_cnt_s == 2'd0) begin
                    state_s = RUN;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = BOOT;
            end
        endcase
    end

    // Fetch PC, counters and FSM state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= BOOT;
            fpc_r      <= RST_WORD;
            out_cnt_r  <= 2'd0;
            disc_cnt_r <= 2'd0;
        end else begin
            state_r    <= state_s;
            fpc_r      <= fpc_s;
            out_cnt_r  <= out_cnt_s;
            disc_cnt_r <= disc_cnt_s;
        end
    end

    // Two-entry in-order response FIFO; a redirect empties it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_pc_r[0]   <= 32'd0;
            fifo_pc_r[1]   <= 32'd0;
            fifo_inst_r[0] <= 32'd0;
            fifo_inst_r[1] <= 32'd0;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
            fifo_cnt_r     <= 2'd0;
        end else if (jmp_en_i) begin
            wr_ptr_r   <= 1'b0;
            rd_ptr_r   <= 1'b0;
            fifo_cnt_r <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]   <= resp_pc_s;
                fifo_inst_r[wr_ptr_r] <= ibus_rdata_i;
                wr_ptr_r              <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Present the FIFO head, or a NOP at the fetch PC when nothing is buffered.
    always_comb begin
        if (fifo_cnt_r != 2'd0) begin
            pc_o   = fifo_pc_r[rd_ptr_r];
            inst_o = fifo_inst_r[rd_ptr_r];
        end else begin
            pc_o   = fpc_r;
            inst_o = NOP_INST;
        end
    end

    assign ibus_req_o  = req_s;
    assign ibus_addr_o = fpc_r;

endmodule

// File: tb/tb_if_fetch.sv
// Directed testbench for if_fetch: an in-order bus responder with a response
// queue, and per-scenario tables of inputs and hand-computed expected outputs.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold_i;
    logic        jmp_en_i;
    logic [31:0] jmp_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] rsp_q [$];
    logic        rsp_en;

    // One table row: inputs for the cycle, then expected req/addr/pc/inst.
    typedef struct packed {
        logic        rst;
        logic        hold;
        logic        jmp;
        logic [31:0] jaddr;
        logic        gnt;
        logic        rsp;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] inst;
    } row_t;

    if_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold_i       (hold_i),
        .jmp_en_i     (jmp_en_i),
        .jmp_addr_i   (jmp_addr_i),
        .ibus_req_o   (ibus_req_o),
        .ibus_addr_o  (ibus_addr_o),
        .ibus_gnt_i   (ibus_gnt_i),
        .ibus_rvalid_i(ibus_rvalid_i),
        .ibus_rdata_i (ibus_rdata_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic row_t mk(input logic r, input logic h, input logic j,
                                input logic [31:0] ja, input logic g, input logic s,
                                input logic q, input logic [31:0] a,
                                input logic [31:0] p, input logic [31:0] n);
        row_t t;
        t = '{rst: r, hold: h, jmp: j, jaddr: ja, gnt: g, rsp: s,
              req: q, addr: a, pc: p, inst: n};
        return t;
    endfunction

    // Advance one clock; the responder returns queued words in order while rsp_en.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = ibus_req_o & ibus_gnt_i;
        a   = ibus_addr_o;
        @(posedge clk);
        #1;
        if (acc) rsp_q.push_back(a);
        if (rsp_en && (rsp_q.size() > 0)) begin
            ibus_rvalid_i = 1'b1;
            ibus_rdata_i  = mem_word(rsp_q.pop_front());
        end else begin
            ibus_rvalid_i = 1'b0;
            ibus_rdata_i  = 32'hDEAD_BEEF;
        end
        #1;
    endtask

    task automatic apply_row(input row_t t);
        rst_n      = t.rst;
        hold_i     = t.hold;
        jmp_en_i   = t.jmp;
        jmp_addr_i = t.jaddr;
        ibus_gnt_i = t.gnt;
        rsp_en     = t.rsp;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hold_i = 1'b0; jmp_en_i = 1'b0; jmp_addr_i = 32'd0;
        ibus_gnt_i = 1'b1; rsp_en = 1'b1;
        tick();
        tick();
        rsp_q.delete();
        ibus_rvalid_i = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [96:0] obs;
        rst_n = 1'b0; hold_i = 1'b0; jmp_en_i = 1'b0; jmp_addr_i = 32'd0;
        ibus_gnt_i = 1'b1; rsp_en = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = {ibus_req_o, ibus_addr_o, pc_o, inst_o};
            n_cmp++;
            if (obs !== {1'b0, 32'd0, 32'd0, NOP}) begin
                n_fail++;
                $display("FAIL reset[%0d]: got req=%b addr=%h pc=%h inst=%h, expected req=0 addr=00000000 pc=00000000 inst=%h",
                         i, ibus_req_o, ibus_addr_o, pc_o, inst_o, NOP);
            end
        end
    endtask

    task automatic test_throughput();
        row_t t [6];
        logic [96:0] obs, exp_v;
        t[0] = mk(1,0,0,0,1,1, 0, 32'h0, 32'h0, NOP);
        t[1] = mk(1,0,0,0,1,1, 1, 32'h0, 32'h0, NOP);
        t[2] = mk(1,0,0,0,1,1, 1, 32'h4, 32'h4, NOP);
        t[3] = mk(1,0,0,0,1,1, 1, 32'h8, 32'h0, mem_word(32'h0));
        t[4] = mk(1,0,0,0,1,1, 1, 32'hC, 32'h4, mem_word(32'h4));
        t[5] = mk(1,0,0,0,1,1, 1, 32'h10, 32'h8, mem_word(32'h8));
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            apply_row(t[i]);
            #1;
            obs   = {ibus_req_o, ibus_addr_o, pc_o, inst_o};
            exp_v = {t[i].req, t[i].addr, t[i].pc, t[i].inst};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL throughput[%0d]: got req=%b addr=%h pc=%h inst=%h, expected req=%b addr=%h pc=%h inst=%h",
                         i, ibus_req_o, ibus_addr_o, pc_o, inst_o, t[i].req, t[i].addr, t[i].pc, t[i].inst);
            end
        end
    endtask

    task automatic test_hold();
        row_t t [12];
        logic [96:0] obs, exp_v;
        t[0]  = mk(1,0,0,0,1,1, 0, 32'h0, 32'h0, NOP);
        t[1]  = mk(1,0,0,0,1,1, 1, 32'h0, 32'h0, NOP);
        t[2]  = mk(1,0,0,0,1,1, 1, 32'h4, 32'h4, NOP);
        t[3]  = mk(1,0,0,0,1,1, 1, 32'h8, 32'h0, mem_word(32'h0));
        for (int k = 4; k < 8; k++) t[k] = mk(1,1,0,0,1,1, 0, 32'hC, 32'h4, mem_word(32'h4));
        t[8]  = mk(1,0,0,0,1,1, 1, 32'hC, 32'h4, mem_word(32'h4));
        t[9]  = mk(1,0,0,0,1,1, 1, 32'h10, 32'h8, mem_word(32'h8));
        t[10] = mk(1,0,0,0,1,1, 1, 32'h14, 32'hC, mem_word(32'hC));
        t[11] = mk(1,0,0,0,1,1, 1, 32'h18, 32'h10, mem_word(32'h10));
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            apply_row(t[i]);
            #1;
            obs   = {ibus_req_o, ibus_addr_o, pc_o, inst_o};
            exp_v = {t[i].req, t[i].addr, t[i].pc, t[i].inst};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL hold[%0d]: got req=%b addr=%h pc=%h inst=%h, expected req=%b addr=%h pc=%h inst=%h",
                         i, ibus_req_o, ibus_addr_o, pc_o, inst_o, t[i].req, t[i].addr, t[i].pc, t[i].inst);
            end
        end
    endtask

    task automatic test_jump_drain();
        row_t t [10];
        logic [96:0] obs, exp_v;
        t[0] = mk(1,0,0,0,1,0, 0, 32'h0, 32'h0, NOP);
        t[1] = mk(1,0,0,0,1,0, 1, 32'h0, 32'h0, NOP);
        t[2] = mk(1,0,0,0,1,0, 1, 32'h4, 32'h4, NOP);
        t[3] = mk(1,0,1,32'h0000_0102,1,0, 0, 32'h8, 32'h8, NOP);
        t[4] = mk(1,0,0,0,1,1, 0, 32'h100, 32'h100, NOP);
        t[5] = mk(1,0,0,0,1,1, 0, 32'h100, 32'h100, NOP);
        t[6] = mk(1,0,0,0,1,1, 0, 32'h100, 32'h100, NOP);
        t[7] = mk(1,0,0,0,1,1, 1, 32'h100, 32'h100, NOP);
        t[8] = mk(1,0,0,0,1,1, 1, 32'h104, 32'h104, NOP);
        t[9] = mk(1,0,0,0,1,1, 1, 32'h108, 32'h100, mem_word(32'h100));
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            apply_row(t[i]);
            #1;
            obs   = {ibus_req_o, ibus_addr_o, pc_o, inst_o};
            exp_v = {t[i].req, t[i].addr, t[i].pc, t[i].inst};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL jump_drain[%0d]: got req=%b addr=%h pc=%h inst=%h, expected req=%b addr=%h pc=%h inst=%h",
                         i, ibus_req_o, ibus_addr_o, pc_o, inst_o, t[i].req, t[i].addr, t[i].pc, t[i].inst);
            end
        end
    endtask

    task automatic test_jump_hold();
        row_t t [7];
        logic [96:0] obs, exp_v;
        t[0] = mk(1,0,0,0,1,1, 0, 32'h0, 32'h0, NOP);
        t[1] = mk(1,0,0,0,1,1, 1, 32'h0, 32'h0, NOP);
        t[2] = mk(1,0,0,0,1,1, 1, 32'h4, 32'h4, NOP);
        t[3] = mk(1,1,1,32'h0000_0200,1,1, 0, 32'h8, 32'h0, mem_word(32'h0));
        t[4] = mk(1,1,0,0,1,1, 1, 32'h200, 32'h200, NOP);
        t[5] = mk(1,0,0,0,1,1, 1, 32'h204, 32'h204, NOP);
        t[6] = mk(1,0,0,0,1,1, 1, 32'h208, 32'h200, mem_word(32'h200));
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            apply_row(t[i]);
            #1;
            obs   = {ibus_req_o, ibus_addr_o, pc_o, inst_o};
            exp_v = {t[i].req, t[i].addr, t[i].pc, t[i].inst};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL jump_hold[%0d]: got req=%b addr=%h pc=%h inst=%h, expected req=%b addr=%h pc=%h inst=%h",
                         i, ibus_req_o, ibus_addr_o, pc_o, inst_o, t[i].req, t[i].addr, t[i].pc, t[i].inst);
            end
        end
    endtask

    task automatic test_wrap();
        row_t t [5];
        logic [96:0] obs, exp_v;
        t[0] = mk(1,0,0,0,0,1, 0, 32'h0, 32'h0, NOP);
        t[1] = mk(1,0,1,32'hFFFF_FFFE,0,1, 1, 32'h0, 32'h0, NOP);
        t[2] = mk(1,0,0,0,1,1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP);
        t[3] = mk(1,0,0,0,1,1, 1, 32'h0, 32'h0, NOP);
        t[4] = mk(1,0,0,0,1,1, 1, 32'h4, 32'hFFFF_FFFC, 32'hA5A5_FFFC);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            apply_row(t[i]);
            #1;
            obs   = {ibus_req_o, ibus_addr_o, pc_o, inst_o};
            exp_v = {t[i].req, t[i].addr, t[i].pc, t[i].inst};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got req=%b addr=%h pc=%h inst=%h, expected req=%b addr=%h pc=%h inst=%h",
                         i, ibus_req_o, ibus_addr_o, pc_o, inst_o, t[i].req, t[i].addr, t[i].pc, t[i].inst);
            end
        end
    endtask

    task automatic test_mid_reset();
        row_t t [7];
        logic [96:0] obs, exp_v;
        t[0] = mk(1,0,0,0,1,0, 0, 32'h0, 32'h0, NOP);
        t[1] = mk(1,0,0,0,1,0, 1, 32'h0, 32'h0, NOP);
        t[2] = mk(0,0,0,0,0,0, 1, 32'h4, 32'h4, NOP);
        t[3] = mk(1,0,0,0,1,1, 0, 32'h0, 32'h0, NOP);
        t[4] = mk(1,0,0,0,1,1, 1, 32'h0, 32'h0, NOP);
        t[5] = mk(1,0,0,0,1,1, 1, 32'h4, 32'h4, NOP);
        t[6] = mk(1,0,0,0,1,1, 1, 32'h8, 32'h0, mem_word(32'h0));
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            apply_row(t[i]);
            #1;
            obs   = {ibus_req_o, ibus_addr_o, pc_o, inst_o};
            exp_v = {t[i].req, t[i].addr, t[i].pc, t[i].inst};
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_reset[%0d]: got req=%b addr=%h pc=%h inst=%h, expected req=%b addr=%h pc=%h inst=%h",
                         i, ibus_req_o, ibus_addr_o, pc_o, inst_o, t[i].req, t[i].addr, t[i].pc, t[i].inst);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_throughput();
        test_hold();
        test_jump_drain();
        test_jump_hold();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
